// File: rtl/seg_scan_if.sv
// Pin-level bundle between a 3-digit scanned 7-segment display and its decoder.
// The display driver is the master; the decoder is the slave.
interface seg_scan_if;
  logic [6:0] seg_in;
  logic [3:0] cathode_in;
  logic [7:0] value;
  logic       value_valid;
  logic       frame_err;
  logic [1:0] err_code;
  logic       locked;

  modport master (
    output seg_in, cathode_in,
    input  value, value_valid, frame_err, err_code, locked
  );

  modport slave (
    input  seg_in, cathode_in,
    output value, value_valid, frame_err, err_code, locked
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers the 8-bit value shown on a multiplexed 3-digit 7-segment display
// by sampling segments/cathodes, settling each dwell and reassembling H/T/O.
module seg_scan_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  seg_scan_if.slave  bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, GOT_H, GOT_T} state_e;
  typedef enum logic [1:0] {POS_H, POS_T, POS_O, POS_BLANK} pos_e;

  logic [SYNC_STAGES-1:0][10:0] sync_q;
  logic [10:0]   s, s_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          capture;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      s_prev_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync_q[0] <= {bus.cathode_in, bus.seg_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_prev_q <= s;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (s != s_prev_q)                       cnt_d = CW'(1);
    else if (cnt_q < CW'(SETTLE_CYCLES))     cnt_d = cnt_q + CW'(1);
  end

  // One capture per dwell: only the edge where the count first hits the target.
  assign capture = (cnt_d == CW'(SETTLE_CYCLES)) && (cnt_q != CW'(SETTLE_CYCLES));

  function automatic logic [4:0] dec7(input logic [6:0] p);
    case (p)
      7'b1111110: dec7 = 5'h10;
      7'b0110000: dec7 = 5'h11;
      7'b1101101: dec7 = 5'h12;
      7'b1111001: dec7 = 5'h13;
      7'b0110011: dec7 = 5'h14;
      7'b1011011: dec7 = 5'h15;
      7'b1011111: dec7 = 5'h16;
      7'b1110000: dec7 = 5'h17;
      7'b1111111: dec7 = 5'h18;
      7'b1110011: dec7 = 5'h19;
      default:    dec7 = 5'h00;
    endcase
  endfunction

  logic [4:0] dec;
  logic       dgood;
  logic [3:0] dig;
  pos_e       pos;
  logic [9:0] sum;

  assign dec   = dec7(s[6:0]);
  assign dgood = dec[4];
  assign dig   = dec[3:0];

  always_comb begin
    case (s[10:7])
      4'b1011: pos = POS_H;
      4'b1101: pos = POS_T;
      4'b1110: pos = POS_O;
      default: pos = POS_BLANK;
    endcase
  end

  state_e        state_q;
  logic [3:0]    h_q, t_q;
  logic [7:0]    value_q;
  logic          vv_q, fe_q, locked_q;
  logic [1:0]    err_q;
  logic [TW-1:0] tmo_q;

  assign sum = 10'(h_q) * 10'd100 + 10'(t_q) * 10'd10 + 10'(dig);

  // Frame assembly, error reporting and lock tracking share one register
  // block so locked moves on the same edge as the pulse that causes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      h_q      <= '0;
      t_q      <= '0;
      value_q  <= '0;
      vv_q     <= 1'b0;
      fe_q     <= 1'b0;
      err_q    <= 2'b00;
      locked_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      vv_q <= 1'b0;
      fe_q <= 1'b0;
      if (tmo_q != TW'(TIMEOUT_CYCLES)) tmo_q <= tmo_q + TW'(1);
      if (tmo_q >= TW'(TIMEOUT_CYCLES - 1)) locked_q <= 1'b0;
      if (capture) begin
        case (pos)
          POS_H: begin
            if (dgood) begin
              h_q     <= dig;
              state_q <= GOT_H;
            end else if (state_q != IDLE) begin
              fe_q <= 1'b1; err_q <= 2'b01; locked_q <= 1'b0; state_q <= IDLE;
            end
          end
          POS_T: begin
            if (state_q == GOT_H) begin
              if (dgood) begin
                t_q     <= dig;
                state_q <= GOT_T;
              end else begin
                fe_q <= 1'b1; err_q <= 2'b01; locked_q <= 1'b0; state_q <= IDLE;
              end
            end else if (state_q == GOT_T) begin
              fe_q <= 1'b1; err_q <= 2'b10; locked_q <= 1'b0; state_q <= IDLE;
            end
          end
          POS_O: begin
            if (state_q == GOT_H) begin
              fe_q <= 1'b1; err_q <= 2'b10; locked_q <= 1'b0;
            end else if (state_q == GOT_T) begin
              if (!dgood) begin
                fe_q <= 1'b1; err_q <= 2'b01; locked_q <= 1'b0;
              end else if (sum > 10'd255) begin
                fe_q <= 1'b1; err_q <= 2'b11; locked_q <= 1'b0;
              end else begin
                value_q  <= sum[7:0];
                vv_q     <= 1'b1;
                locked_q <= 1'b1;
                tmo_q    <= '0;
              end
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = vv_q;
  assign bus.frame_err   = fe_q;
  assign bus.err_code    = err_q;
  assign bus.locked      = locked_q;
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the 3-digit multiplexed 7-segment display driver.
- Samples the scanned segment bus (ABCDEFG, active-high) and the active-low digit enables, decodes each digit, and reassembles hundreds/tens/ones into the 8-bit binary value the CPU output.
- Used on a companion board/FPGA and in self-checking benches to recover the CPU output from the display pins alone.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer chain (>=2).
- SETTLE_CYCLES, 4, consecutive stable synchronized cycles required before a digit is captured (>=2).
- TIMEOUT_CYCLES, 4096, cycles without a good frame before `locked` drops.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- seg_in  in  7  segments [6]=A .. [0]=G, active-high
- cathode_in  in  4  digit enables, active-low: 1011=hundreds, 1101=tens, 1110=ones
- value  out  8  last successfully decoded value
- value_valid  out  1  one-cycle pulse when `value` updates
- frame_err  out  1  one-cycle pulse on a decode error
- err_code  out  2  cause of the last error: 01 bad segment pattern, 10 sequence, 11 range >255
- locked  out  1  high while good frames are arriving

Behaviour:
- Clock and reset
  - Clock is clk; reset is asynchronous, active-high.
  - Reset clears all registers. Outputs: value=0, value_valid=0, frame_err=0, err_code=00, locked=0. FSM enters IDLE and the timeout counter clears.
  - Reset asserted mid-frame discards the partial frame.
- Input sampling
  - seg_in and cathode_in each pass through SYNC_STAGES flops.
  - A combined 11-bit sampled word s is compared with its previous value s_prev.
- Settle counter
  - If s != s_prev, cnt <= 1.
  - Else if cnt < SETTLE_CYCLES, cnt <= cnt+1.
  - A capture event fires on the edge where cnt becomes SETTLE_CYCLES. This gives exactly one capture per dwell; dwells shorter than SETTLE_CYCLES are ignored.
- Digit decode at capture
  - Patterns decode 0..9: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1110011.
  - Any other pattern, including blank, is bad.
  - A cathode other than the three listed (e.g. 1111 or multiple lows) is a blank position.
- FSM states: IDLE, GOT_H, GOT_T.
  - Hundreds capture, any state: if the pattern is good, store h and go to GOT_H. If bad in IDLE, stay IDLE silently. If bad in GOT_H/GOT_T, raise error 01 and go to IDLE.
  - IDLE, tens/ones/blank capture: ignored silently (frame-start hunting; covers the post-reset blank on 1110).
  - GOT_H, tens good: store t and go to GOT_T. Tens bad: error 01, IDLE. Ones: error 10, IDLE. Blank position: abort to IDLE, no error.
  - GOT_T, ones good: compute h*100 + t*10 + o in 10 bits.
    - If <=255: on that same capture edge, value <= result, value_valid pulses, and go to IDLE.
    - If >255: error 11, value unchanged, IDLE.
  - GOT_T, ones bad: error 01, IDLE. Tens: error 10, IDLE. Blank: abort to IDLE, no error.
- Error handling
  - Error means: on the capture edge, frame_err pulses for one cycle and err_code is updated. err_code holds until the next error or reset.
- Latency
  - value_valid rises SYNC_STAGES + SETTLE_CYCLES clk edges after the ones digit appears at the pins (6 with defaults).
- locked
  - Set on value_valid.
  - Cleared on frame_err.
  - Cleared when the timeout counter, zeroed by each value_valid, reaches TIMEOUT_CYCLES. The counter saturates there.
  - If value_valid and timeout coincide, value_valid wins.
- value_valid and frame_err are mutually exclusive.

Test Plan:
- Scan frames hundreds 0 (1111110 on 1011), tens 5 (1011011 on 1101), ones 5 (1011011 on 1110), 20 cycles each, looped -> value=55, one value_valid per frame exactly 6 edges after each ones change, locked=1, frame_err never.
- Frame 2,5,5 -> value=255 valid. Then frame 2,5,6 -> frame_err pulse, err_code=11, value stays 255, locked=0. Then frame 0,4,2 -> value=42, locked=1.
- Tens pattern 0000001 inside a frame -> frame_err, err_code=01. Next clean frame 1,4,4 -> value=144.
- Hundreds 1, then tens held only 3 cycles (glitch, not captured), then ones 7 -> err_code=10, no value_valid. Dwell of exactly 4 cycles is captured.
- After reset, inputs 1110/0000000 -> no pulses. Cathode 1111 between tens and ones -> silent abort, no value. Reset asserted mid-frame, then a full frame 0,0,9 -> value=9.
- TIMEOUT_CYCLES=64: one good frame, then inputs frozen -> locked falls exactly 64 cycles after value_valid. The next good frame re-asserts it.
